// File: rtl/alu_param.sv
`default_nettype none
// ============================================================================
// Module   : alu_param
// Purpose  : Registered-operand ALU sequenced by a small FSM, with flags,
//            abort/freeze control and an optional shift-add multiplier
//            (built only when ALU_MUL_EN is defined).
// Revision : 1.0  initial release
// ============================================================================
module alu_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic [2:0]       in_sel,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [6:0]       out_sel,
    output logic [WIDTH-1:0] final1,
    output logic [WIDTH-1:0] final2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             err,
    output logic             valid,
    output logic             busy,
    output logic [1:0]       currState,
    output logic [1:0]       nextState
);

    localparam logic [6:0] OP_ADD = 7'b100_0000;
    localparam logic [6:0] OP_SUB = 7'b010_0000;
    localparam logic [6:0] OP_AND = 7'b001_0000;
    localparam logic [6:0] OP_OR  = 7'b000_1000;
    localparam logic [6:0] OP_XOR = 7'b000_0100;
    localparam logic [6:0] OP_NOT = 7'b000_0010;
    localparam logic [6:0] OP_MUL = 7'b000_0001;

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] final1_q, final1_d, final2_q, final2_d;
    logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
    logic [6:0]       op_q, op_d;
    logic             carry_q, carry_d, zero_q, zero_d;
    logic             ovf_q, ovf_d, err_q, err_d;

    logic             cmd_load, cmd_clear, op_legal, is_mul, abort;
    logic [WIDTH:0]   sum_w, diff_w;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry, alu_ovf;
    logic             a_msb, b_msb;

    assign cmd_load  = (in_sel == 3'b010);
    assign cmd_clear = (in_sel == 3'b001);
    assign op_legal  = $onehot(op_q) && !(op_q[0] && !MUL_EN);
    assign is_mul    = MUL_EN && (op_q == OP_MUL);
    assign a_msb     = final1_q[WIDTH-1];
    assign b_msb     = final2_q[WIDTH-1];

    // Single-cycle datapath; illegal op codes fall through to all-zero results
    always_comb begin
        sum_w     = {1'b0, final1_q} + {1'b0, final2_q};
        diff_w    = {1'b0, final1_q} - {1'b0, final2_q};
        alu_out   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        if (op_legal) begin
            case (op_q)
                OP_ADD: begin
                    alu_out   = sum_w[WIDTH-1:0];
                    alu_carry = sum_w[WIDTH];
                    alu_ovf   = (a_msb == b_msb) && (sum_w[WIDTH-1] != a_msb);
                end
                OP_SUB: begin
                    alu_out   = diff_w[WIDTH-1:0];
                    alu_carry = diff_w[WIDTH];
                    alu_ovf   = (a_msb != b_msb) && (diff_w[WIDTH-1] != a_msb);
                end
                OP_AND:  alu_out = final1_q & final2_q;
                OP_OR:   alu_out = final1_q | final2_q;
                OP_XOR:  alu_out = final1_q ^ final2_q;
                OP_NOT:  alu_out = ~final1_q;
                default: alu_out = '0;
            endcase
        end
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
    logic [WIDTH:0]     part_w;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mul_last;

    // Upper half accumulates A when the multiplier LSB is set, then the
    // whole product register shifts right, consuming one multiplier bit.
    always_comb begin
        part_w    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, final1_q} : {(WIDTH+1){1'b0}});
        prod_step = {part_w, prod_q[WIDTH-1:1]};
        mul_last  = (cnt_q == CNT_W'(WIDTH-1));
    end
`endif

    always_comb begin
        state_d  = state_q;
        final1_d = final1_q;
        final2_d = final2_q;
        op_d     = op_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        abort    = 1'b0;
`ifdef ALU_MUL_EN
        prod_d   = prod_q;
        cnt_d    = cnt_q;
`endif
        if (on) begin
            case (state_q)
                IDLE: begin
                    if (cmd_load) begin
                        final1_d = num1;
                        final2_d = num2;
                        op_d     = out_sel;
                        err_d    = 1'b0;
                        state_d  = EXEC;
                    end else if (cmd_clear) begin
                        final1_d = '0;
                        final2_d = '0;
                        out_d    = '0;
                        out_hi_d = '0;
                        carry_d  = 1'b0;
                        zero_d   = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b0;
                    end
                end
                EXEC: begin
                    if (cmd_clear) begin
                        abort = 1'b1;
                    end else if (is_mul) begin
`ifdef ALU_MUL_EN
                        prod_d  = {{WIDTH{1'b0}}, final2_q};
                        cnt_d   = '0;
`endif
                        state_d = MUL;
                    end else begin
                        out_d    = alu_out;
                        out_hi_d = '0;
                        carry_d  = alu_carry;
                        ovf_d    = alu_ovf;
                        err_d    = !op_legal;
                        zero_d   = op_legal && (alu_out == '0);
                        state_d  = DONE;
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    if (cmd_clear) begin
                        abort = 1'b1;
                    end else begin
                        prod_d = prod_step;
                        cnt_d  = cnt_q + 1'b1;
                        if (mul_last) begin
                            out_d    = prod_step[WIDTH-1:0];
                            out_hi_d = prod_step[2*WIDTH-1:WIDTH];
                            carry_d  = (prod_step[2*WIDTH-1:WIDTH] != '0);
                            zero_d   = (prod_step == '0);
                            ovf_d    = 1'b0;
                            err_d    = 1'b0;
                            state_d  = DONE;
                        end
                    end
                end
`endif
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Abort wipes every register so no stale result leaks out afterwards
        if (abort) begin
            state_d  = IDLE;
            final1_d = '0;
            final2_d = '0;
            op_d     = '0;
            out_d    = '0;
            out_hi_d = '0;
            carry_d  = 1'b0;
            zero_d   = 1'b0;
            ovf_d    = 1'b0;
            err_d    = 1'b0;
`ifdef ALU_MUL_EN
            prod_d   = '0;
            cnt_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            final1_q <= '0;
            final2_q <= '0;
            op_q     <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            final1_q <= final1_d;
            final2_q <= final2_d;
            op_q     <= op_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_q <= '0;
            cnt_q  <= '0;
        end else begin
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
        end
    end
`endif

    assign final1    = final1_q;
    assign final2    = final2_q;
    assign out       = out_q;
    assign out_hi    = out_hi_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign valid     = (state_q == DONE) && on;
    assign busy      = (state_q == EXEC) || (state_q == MUL);
    assign currState = state_q;
    assign nextState = state_d;

endmodule
`default_nettype wire

// File: tb/tb_alu_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_param
// Purpose  : Self-checking bench for alu_param (WIDTH=8); expectations come
//            from an arithmetic reference model. Honours ALU_MUL_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_param;

    localparam int W    = 8;
    localparam int FULL = 2 ** W;
    localparam int HALF = 2 ** (W - 1);
`ifdef ALU_MUL_EN
    localparam bit MUL_OK = 1'b1;
`else
    localparam bit MUL_OK = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
        logic         v;
        logic         e;
        logic         mul;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         on  = 1'b1;
    logic [2:0]   in_sel = 3'b000;
    logic [W-1:0] num1 = '0, num2 = '0;
    logic [6:0]   out_sel = '0;
    logic [W-1:0] final1, final2, out, out_hi;
    logic         carry, zero, ovf, err, valid, busy;
    logic [1:0]   currState, nextState;

    int checks = 0;
    int errors = 0;

    alu_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .on(on), .in_sel(in_sel),
        .num1(num1), .num2(num2), .out_sel(out_sel),
        .final1(final1), .final2(final2), .out(out), .out_hi(out_hi),
        .carry(carry), .zero(zero), .ovf(ovf), .err(err),
        .valid(valid), .busy(busy),
        .currState(currState), .nextState(nextState)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [6:0] sel);
        res_t r;
        int ia, ib, sa, sb, full;
        r  = '0;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= HALF) ? ia - FULL : ia;
        sb = (ib >= HALF) ? ib - FULL : ib;
        if ($countones(sel) != 1 || (sel == 7'b000_0001 && !MUL_OK)) begin
            r.e = 1'b1;
            return r;
        end
        case (sel)
            7'b100_0000: begin
                full  = ia + ib;
                r.out = W'(full % FULL);
                r.c   = (full >= FULL);
                r.v   = (sa + sb > HALF - 1) || (sa + sb < -HALF);
            end
            7'b010_0000: begin
                full  = ia - ib;
                r.out = W'((full + FULL) % FULL);
                r.c   = (ia < ib);
                r.v   = (sa - sb > HALF - 1) || (sa - sb < -HALF);
            end
            7'b001_0000: r.out = a & b;
            7'b000_1000: r.out = a | b;
            7'b000_0100: r.out = a ^ b;
            7'b000_0010: r.out = ~a;
            default: begin
                full  = ia * ib;
                r.out = W'(full % FULL);
                r.hi  = W'(full / FULL);
                r.c   = (r.hi != '0);
                r.mul = 1'b1;
            end
        endcase
        r.z = (r.out == '0) && (r.hi == '0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input res_t e);
        check("out",    32'(out),    32'(e.out));
        check("out_hi", 32'(out_hi), 32'(e.hi));
        check("carry",  32'(carry),  32'(e.c));
        check("zero",   32'(zero),   32'(e.z));
        check("ovf",    32'(ovf),    32'(e.v));
        check("err",    32'(err),    32'(e.e));
    endtask

    task automatic check_cleared();
        check("clr_state",  32'(currState), 32'd0);
        check("clr_final1", 32'(final1),    32'd0);
        check("clr_final2", 32'(final2),    32'd0);
        check("clr_valid",  32'(valid),     32'd0);
        check_res('0);
    endtask

    // Load one operation, optionally freezing fn cycles while it runs,
    // then verify latency, result, flags and that a load in DONE is dropped.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [6:0] sel, input int fn);
        res_t e;
        int   base, fs, lat;
        bit   seen;
        e    = model(a, b, sel);
        base = e.mul ? W + 1 : 1;
        fs   = (base > 4) ? 4 : 0;
        @(negedge clk);
        num1 = a; num2 = b; out_sel = sel; in_sel = 3'b010;
        #1 check("next_load", 32'(nextState), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_sel  = 3'b000;
        out_sel = 7'($urandom);
        num1    = W'($urandom);
        num2    = W'($urandom);
        check("final1", 32'(final1), 32'(a));
        check("final2", 32'(final2), 32'(b));
        check("busy",   32'(busy),   32'd1);
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            on = !(k > fs && k <= fs + fn);
            @(posedge clk);
            @(negedge clk);
            if (valid) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        on = 1'b1;
        check("latency", 32'(lat), 32'(base + fn));
        check_res(e);
        num1   = ~a;
        in_sel = 3'b010;
        @(posedge clk);
        @(negedge clk);
        in_sel = 3'b000;
        check("valid_pulse", 32'(valid),     32'd0);
        check("back_idle",   32'(currState), 32'd0);
        check("done_load",   32'(final1),    32'(a));
    endtask

    initial begin
        res_t e;
        logic [6:0] sel;

        #2;
        check("rst_state", 32'(currState), 32'd0);
        check("rst_next",  32'(nextState), 32'd0);
        check_cleared();
        @(negedge clk);
        rst = 1'b1;

        // Directed arithmetic cases
        do_op(8'h57, 8'h1A, 7'b100_0000, 0);
        do_op(8'h02, 8'h04, 7'b010_0000, 0);
        do_op(8'h7F, 8'h01, 7'b100_0000, 0);
        do_op(8'h57, 8'h1A, 7'b000_0001, 0);
        do_op(8'h57, 8'h1A, 7'b000_0001, 3);

        // Persist holds, clear in IDLE zeroes
        do_op(8'hF0, 8'h33, 7'b000_0100, 0);
        e = model(8'hF0, 8'h33, 7'b000_0100);
        @(negedge clk);
        in_sel = 3'b100;
        @(posedge clk);
        @(negedge clk);
        check("persist_state", 32'(currState), 32'd0);
        check_res(e);
        in_sel = 3'b001;
        @(posedge clk);
        @(negedge clk);
        in_sel = 3'b000;
        check_cleared();

        // Frozen load is ignored
        on = 1'b0; num1 = 8'hAA; num2 = 8'h55; out_sel = 7'b100_0000; in_sel = 3'b010;
        #1 check("frz_next", 32'(nextState), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("frz_state",  32'(currState), 32'd0);
        check("frz_final1", 32'(final1),    32'd0);
        on = 1'b1; in_sel = 3'b000;

        // Clear while the multiply is in flight
        do_op(8'h11, 8'h22, 7'b001_0000, 0);
        @(negedge clk);
        num1 = 8'h57; num2 = 8'h1A; out_sel = 7'b000_0001; in_sel = 3'b010;
        @(posedge clk);
        @(negedge clk);
        in_sel = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_sel = 3'b001;
        @(posedge clk);
        @(negedge clk);
        in_sel = 3'b000;
        check_cleared();
        for (int k = 0; k < W + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_novalid", 32'(valid), 32'd0);
        end

        // Illegal op then recovery
        do_op(8'h12, 8'h34, 7'b000_0011, 0);
        do_op(8'h12, 8'h34, 7'b000_0010, 0);

        // Randomised operations with occasional freezes and illegal codes
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) sel = 7'($urandom);
            else                           sel = 7'(1 << $urandom_range(0, 6));
            do_op(W'($urandom), W'($urandom), sel, int'($urandom_range(0, 2)));
        end
        do_op(8'h00, 8'h00, 7'b000_0001, 0);
        do_op(8'h80, 8'h01, 7'b010_0000, 0);

        // Asynchronous reset mid-run
        @(negedge clk);
        num1 = 8'hFF; num2 = 8'hFF; out_sel = 7'b000_0001; in_sel = 3'b010;
        @(posedge clk);
        @(negedge clk);
        in_sel = 3'b000;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_cleared();
        @(negedge clk);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
`default_nettype wire
